state_sequencer: RTL and testbench

STATE_SEQUENCER -- requirements
Module: state_sequencer

---
 rtl/state_sequencer.sv | 162 ++++++++++++++++
 tb/tb_state_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/state_sequencer.sv
// Multi-cycle control sequencer: walks FETCH/DECODE/execute chains and emits StateID for the control decoder.
// Optional LM/SM block transfers are compiled in with `define LMSM_EN.
module state_sequencer #(
   parameter int STATE_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [15:0]        IR,
   input  logic               mem_ready,
   input  logic               C_flag,
   input  logic               Z_flag,
   input  logic               eq,
   output logic [STATE_W-1:0] StateID,
   output logic [2:0]         lmsm_idx,
   output logic               lmsm_last,
   output logic               illegal
);

   typedef enum logic [STATE_W-1:0] {
      FETCH     = STATE_W'(0),
      ADD_EX    = STATE_W'(1),
      ADD_WB    = STATE_W'(2),
      DECODE    = STATE_W'(3),
      NDU_EX    = STATE_W'(8),
      NDU_WB    = STATE_W'(9),
      ADI_EX    = STATE_W'(11),
      ADI_WB    = STATE_W'(12),
      LHI_WB    = STATE_W'(13),
      MEM_ADDR  = STATE_W'(14),
      LW_RD     = STATE_W'(15),
      LW_WB     = STATE_W'(16),
      SW_WR     = STATE_W'(17),
      LMSM_INIT = STATE_W'(18),
      LM_RD     = STATE_W'(19),
      SM_WR     = STATE_W'(20),
      BEQ_CMP   = STATE_W'(21),
      BEQ_TAKE  = STATE_W'(22),
      JAL       = STATE_W'(23),
      JLR       = STATE_W'(24),
      PC_INC    = STATE_W'(25)
   } state_t;

   state_t     state, next_state;
   logic [3:0] opcode;
   logic       cond_ok, cond_bad, illegal_c;
   logic       unused_ir;

   assign opcode    = IR[15:12];
   assign StateID   = state;
   assign unused_ir = ^IR;

   // ADD/NDU condition codes: 00 always, 01 needs Z, 10 needs C, 11 undefined
   assign cond_bad = (IR[1:0] == 2'b11);
   always_comb begin
      cond_ok = 1'b0;
      case (IR[1:0])
         2'b00:   cond_ok = 1'b1;
         2'b01:   cond_ok = Z_flag;
         2'b10:   cond_ok = C_flag;
         default: cond_ok = 1'b0;
      endcase
   end

`ifdef LMSM_EN
   logic [7:0] mask, mask_clr;
   logic [2:0] idx;

   function automatic logic [2:0] lowest_bit(input logic [7:0] m);
      lowest_bit = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) lowest_bit = 3'(i);
   endfunction

   assign mask_clr = mask & ~(8'b1 << idx);

   always_ff @(posedge clk) begin
      if (reset) begin
         mask <= 8'd0;
         idx  <= 3'd0;
      end else if (state == LMSM_INIT) begin
         mask <= IR[7:0];
         idx  <= lowest_bit(IR[7:0]);
      end else if ((state == LM_RD || state == SM_WR) && mem_ready) begin
         mask <= mask_clr;
         idx  <= lowest_bit(mask_clr);
      end
   end

   assign lmsm_idx  = idx;
   assign lmsm_last = (state == LM_RD || state == SM_WR) && (mask != 8'd0) &&
                      ((mask & (mask - 8'd1)) == 8'd0);
`else
   assign lmsm_idx  = 3'd0;
   assign lmsm_last = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      illegal_c  = 1'b0;
      case (state)
         FETCH:    if (mem_ready) next_state = DECODE;
         DECODE: begin
            case (opcode)
               4'b0000: begin
                  illegal_c  = cond_bad;
                  next_state = cond_ok ? ADD_EX : PC_INC;
               end
               4'b0010: begin
                  illegal_c  = cond_bad;
                  next_state = cond_ok ? NDU_EX : PC_INC;
               end
               4'b0001:          next_state = ADI_EX;
               4'b0011:          next_state = LHI_WB;
               4'b0100, 4'b0101: next_state = MEM_ADDR;
`ifdef LMSM_EN
               4'b0110, 4'b0111: next_state = LMSM_INIT;
`endif
               4'b1100:          next_state = BEQ_CMP;
               4'b1000:          next_state = JAL;
               4'b1001:          next_state = JLR;
               default: begin
                  illegal_c  = 1'b1;
                  next_state = PC_INC;
               end
            endcase
         end
         ADD_EX:   next_state = ADD_WB;
         ADD_WB:   next_state = PC_INC;
         NDU_EX:   next_state = NDU_WB;
         NDU_WB:   next_state = PC_INC;
         ADI_EX:   next_state = ADI_WB;
         ADI_WB:   next_state = PC_INC;
         LHI_WB:   next_state = PC_INC;
         MEM_ADDR: next_state = opcode[0] ? SW_WR : LW_RD;
         LW_RD:    if (mem_ready) next_state = LW_WB;
         LW_WB:    next_state = PC_INC;
         SW_WR:    if (mem_ready) next_state = PC_INC;
`ifdef LMSM_EN
         LMSM_INIT: begin
            if (IR[7:0] == 8'd0) next_state = PC_INC;
            else                 next_state = opcode[0] ? SM_WR : LM_RD;
         end
         LM_RD, SM_WR:
            if (mem_ready && mask_clr == 8'd0) next_state = PC_INC;
`endif
         BEQ_CMP:  next_state = eq ? BEQ_TAKE : PC_INC;
         BEQ_TAKE: next_state = FETCH;
         JAL:      next_state = FETCH;
         JLR:      next_state = FETCH;
         PC_INC:   next_state = FETCH;
         default:  next_state = FETCH;
      endcase
   end

   assign illegal = illegal_c & ~reset;

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer: StateID traces per instruction class, LM/SM indexing and reset.
module tb_state_sequencer;
   logic        clk = 1'b0;
   logic        reset, mem_ready, C_flag, Z_flag, eq;
   logic [15:0] IR;
   logic [4:0]  StateID;
   logic [2:0]  lmsm_idx;
   logic        lmsm_last, illegal;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   state_sequencer #(.STATE_W(5)) dut (
      .clk(clk), .reset(reset), .IR(IR), .mem_ready(mem_ready),
      .C_flag(C_flag), .Z_flag(Z_flag), .eq(eq),
      .StateID(StateID), .lmsm_idx(lmsm_idx), .lmsm_last(lmsm_last), .illegal(illegal)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [4:0] exp_q[$];
      reset = 1'b1; mem_ready = 1'b0; IR = 16'h0000;
      C_flag = 1'b0; Z_flag = 1'b0; eq = 1'b0;
      step; step;
      checks++;
      if (StateID !== 5'd0 || lmsm_idx !== 3'd0 || lmsm_last !== 1'b0 || illegal !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs state=%0d idx=%0d last=%b ill=%b expected 0,0,0,0",
                  StateID, lmsm_idx, lmsm_last, illegal);
      end
      reset = 1'b0;
      step;
      checks++;
      if (StateID !== 5'd0) begin
         failures++;
         $display("FAIL fetch_hold state=%0d expected=0", StateID);
      end
      mem_ready = 1'b1;
      exp_q = '{5'd3, 5'd1, 5'd2, 5'd25, 5'd0};
      for (int i = 0; i < exp_q.size(); i++) begin
         step;
         checks++;
         if (StateID !== exp_q[i]) begin
            failures++;
            $display("FAIL add_after_reset[%0d] state=%0d expected=%0d", i, StateID, exp_q[i]);
         end
      end
   endtask

   task automatic test_adc;
      logic [4:0] exp_q[$];
      IR = 16'h0002; C_flag = 1'b0; mem_ready = 1'b1;
      exp_q = '{5'd0, 5'd3, 5'd25, 5'd0};
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) step;
         checks++;
         if (StateID !== exp_q[i]) begin
            failures++;
            $display("FAIL adc_c0[%0d] state=%0d expected=%0d", i, StateID, exp_q[i]);
         end
      end
      C_flag = 1'b1;
      exp_q = '{5'd0, 5'd3, 5'd1, 5'd2, 5'd25, 5'd0};
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) step;
         checks++;
         if (StateID !== exp_q[i]) begin
            failures++;
            $display("FAIL adc_c1[%0d] state=%0d expected=%0d", i, StateID, exp_q[i]);
         end
      end
      C_flag = 1'b0;
   endtask

   task automatic test_chains;
      logic [15:0] irs [10];
      logic        eqs [10];
      int          seqs[10][7];
      irs  = '{16'h0000, 16'h2000, 16'h1000, 16'h3000, 16'h5000,
               16'h8000, 16'h9000, 16'h2001, 16'hC000, 16'hC000};
      eqs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      seqs = '{'{0, 3, 1, 2, 25, 0, -1},
               '{0, 3, 8, 9, 25, 0, -1},
               '{0, 3, 11, 12, 25, 0, -1},
               '{0, 3, 13, 25, 0, -1, -1},
               '{0, 3, 14, 17, 25, 0, -1},
               '{0, 3, 23, 0, -1, -1, -1},
               '{0, 3, 24, 0, -1, -1, -1},
               '{0, 3, 25, 0, -1, -1, -1},
               '{0, 3, 21, 22, 0, -1, -1},
               '{0, 3, 21, 25, 0, -1, -1}};
      mem_ready = 1'b1; Z_flag = 1'b0; C_flag = 1'b0;
      for (int t = 0; t < 10; t++) begin
         IR = irs[t]; eq = eqs[t];
         for (int i = 0; i < 7 && seqs[t][i] >= 0; i++) begin
            if (i > 0) step;
            checks++;
            if (StateID !== 5'(seqs[t][i]) || illegal !== 1'b0) begin
               failures++;
               $display("FAIL chain_%h[%0d] state=%0d ill=%b expected state=%0d ill=0",
                        irs[t], i, StateID, illegal, seqs[t][i]);
            end
         end
      end
      eq = 1'b0;
   endtask

   task automatic test_lw_stall;
      logic [4:0] exp_q[$];
      logic       mr_q[$];
      IR = 16'h4000; mem_ready = 1'b1;
      exp_q = '{5'd0, 5'd3, 5'd14, 5'd15, 5'd15, 5'd15, 5'd15, 5'd16, 5'd25, 5'd0};
      mr_q  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) step;
         checks++;
         if (StateID !== exp_q[i]) begin
            failures++;
            $display("FAIL lw_stall[%0d] state=%0d expected=%0d", i, StateID, exp_q[i]);
         end
         mem_ready = mr_q[i];
      end
   endtask

   task automatic test_illegal;
      logic [4:0] exp_q[$];
      logic       ill_q[$];
      IR = 16'hF000; mem_ready = 1'b1;
      exp_q = '{5'd0, 5'd3, 5'd25, 5'd0};
      ill_q = '{1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) step;
         checks++;
         if (StateID !== exp_q[i] || illegal !== ill_q[i]) begin
            failures++;
            $display("FAIL illegal_F000[%0d] state=%0d ill=%b expected state=%0d ill=%b",
                     i, StateID, illegal, exp_q[i], ill_q[i]);
         end
      end
   endtask

`ifdef LMSM_EN
   task automatic test_lmsm;
      logic [4:0] exp_q[$];
      logic [2:0] idx_q[$];
      logic       last_q[$];
      mem_ready = 1'b1;
      IR = 16'h60A5;
      exp_q  = '{5'd0, 5'd3, 5'd18, 5'd19, 5'd19, 5'd19, 5'd19, 5'd25, 5'd0};
      idx_q  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd0};
      last_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) step;
         checks++;
         if (StateID !== exp_q[i] || lmsm_last !== last_q[i] ||
             (exp_q[i] == 5'd19 && lmsm_idx !== idx_q[i])) begin
            failures++;
            $display("FAIL lm_60A5[%0d] state=%0d idx=%0d last=%b expected state=%0d idx=%0d last=%b",
                     i, StateID, lmsm_idx, lmsm_last, exp_q[i], idx_q[i], last_q[i]);
         end
      end
      IR = 16'h7080;
      exp_q = '{5'd0, 5'd3, 5'd18, 5'd20, 5'd25, 5'd0};
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) step;
         checks++;
         if (StateID !== exp_q[i] || (exp_q[i] == 5'd20 && (lmsm_idx !== 3'd7 || lmsm_last !== 1'b1))) begin
            failures++;
            $display("FAIL sm_7080[%0d] state=%0d idx=%0d last=%b expected state=%0d",
                     i, StateID, lmsm_idx, lmsm_last, exp_q[i]);
         end
      end
      IR = 16'h6000;
      exp_q = '{5'd0, 5'd3, 5'd18, 5'd25, 5'd0};
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) step;
         checks++;
         if (StateID !== exp_q[i] || lmsm_last !== 1'b0) begin
            failures++;
            $display("FAIL lm_empty[%0d] state=%0d last=%b expected state=%0d last=0",
                     i, StateID, lmsm_last, exp_q[i]);
         end
      end
      IR = 16'h60A5;
      step; step; step; step;
      checks++;
      if (StateID !== 5'd19 || lmsm_idx !== 3'd2) begin
         failures++;
         $display("FAIL lm_pre_reset state=%0d idx=%0d expected state=19 idx=2", StateID, lmsm_idx);
      end
      reset = 1'b1;
      step;
      checks++;
      if (StateID !== 5'd0 || lmsm_idx !== 3'd0 || lmsm_last !== 1'b0) begin
         failures++;
         $display("FAIL lm_mid_reset state=%0d idx=%0d last=%b expected 0,0,0",
                  StateID, lmsm_idx, lmsm_last);
      end
      mem_ready = 1'b0;
      reset = 1'b0;
   endtask
`else
   task automatic test_lmsm;
      logic [4:0] exp_q[$];
      logic       ill_q[$];
      mem_ready = 1'b1;
      IR = 16'h70FF;
      exp_q = '{5'd0, 5'd3, 5'd25, 5'd0};
      ill_q = '{1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) step;
         checks++;
         if (StateID !== exp_q[i] || illegal !== ill_q[i] || lmsm_idx !== 3'd0 || lmsm_last !== 1'b0) begin
            failures++;
            $display("FAIL sm_disabled[%0d] state=%0d ill=%b idx=%0d last=%b expected state=%0d ill=%b idx=0 last=0",
                     i, StateID, illegal, lmsm_idx, lmsm_last, exp_q[i], ill_q[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset;
      test_adc;
      test_chains;
      test_lw_stall;
      test_illegal;
      test_lmsm;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
